// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, character-cell geometry and the
// sync bundle type carried through the output delay line.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int CHAR_W   = 8;
  localparam int CHAR_H   = 16;
  localparam int COLS     = H_ACTIVE / CHAR_W;
  localparam int ROWS     = V_ACTIVE / CHAR_H;
  localparam int ADDR_W   = 13;

  localparam int GLYPH_X_W = $clog2(CHAR_W);
  localparam int GLYPH_Y_W = $clog2(CHAR_H);
  localparam int CNT_W     = 10;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } sync_t;

  // Blanked, both syncs deasserted (they are active-low)
  localparam sync_t SYNC_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/vga_sync_delay.sv
// Strobe-gated shift register that lines up active/hsync/vsync with the
// character RAM + glyph ROM read latency downstream.
module vga_sync_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  sync_t din,
  output sync_t dout
);

  if (DEPTH == 0) begin : g_bypass
    assign dout = din;
  end else begin : g_pipe
    sync_t stage_r [DEPTH];

    // Shift only on pixel strobes; reset fills every stage with the idle pattern
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          stage_r[i] <= SYNC_IDLE;
        end
      end else if (en) begin
        stage_r[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_r[i] <= stage_r[i-1];
        end
      end else begin
        stage_r <= stage_r;
      end
    end

    assign dout = stage_r[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel timing and character-cell addressing; sync/active are delayed
// to match the character RAM + glyph ROM read latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter int CHAR_W   = vga_pkg::CHAR_W,
  parameter int CHAR_H   = vga_pkg::CHAR_H,
  parameter int ADDR_W   = vga_pkg::ADDR_W,
  parameter int PIPE_DLY = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  output logic                      pix_en_o,
  output logic [CNT_W-1:0]          hcnt_o,
  output logic [CNT_W-1:0]          vcnt_o,
  output logic [ADDR_W-1:0]         char_addr_o,
  output logic [$clog2(CHAR_W)-1:0] glyph_x_o,
  output logic [$clog2(CHAR_H)-1:0] glyph_y_o,
  output logic                      active_o,
  output logic                      hsync_o,
  output logic                      vsync_o,
  output logic                      frame_start_o
);

  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_ACTIVE + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC;
  localparam int VS_BEG = V_ACTIVE + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC;
  localparam int COLS_L = H_ACTIVE / CHAR_W;
  localparam int GX_W   = $clog2(CHAR_W);
  localparam int GY_W   = $clog2(CHAR_H);
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]  div_r;
  logic              pix_en_s;
  logic [CNT_W-1:0]  hcnt_r;
  logic [CNT_W-1:0]  vcnt_r;
  logic [ADDR_W-1:0] row_base_r;
  logic              h_last_s;
  logic              v_last_s;
  logic              row_step_s;
  logic [CNT_W-1:0]  col_s;
  sync_t             raw_s;
  sync_t             dly_s;

  assign pix_en_s = (div_r == DIV_W'(CLK_DIV - 1));
  assign h_last_s = (hcnt_r == CNT_W'(H_TOT - 1));
  assign v_last_s = (vcnt_r == CNT_W'(V_TOT - 1));

  // Pixel-rate divider; with CLK_DIV == 1 it sits at 0 and the strobe is constant
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_r <= {DIV_W{1'b0}};
    end else if (pix_en_s) begin
      div_r <= {DIV_W{1'b0}};
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Raster counters, advancing once per pixel strobe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt_r <= {CNT_W{1'b0}};
      vcnt_r <= {CNT_W{1'b0}};
    end else if (pix_en_s) begin
      if (h_last_s) begin
        hcnt_r <= {CNT_W{1'b0}};
        vcnt_r <= v_last_s ? {CNT_W{1'b0}} : (vcnt_r + CNT_W'(1));
      end else begin
        hcnt_r <= hcnt_r + CNT_W'(1);
        vcnt_r <= vcnt_r;
      end
    end else begin
      hcnt_r <= hcnt_r;
      vcnt_r <= vcnt_r;
    end
  end

  // Step to the next text row only when the line after this one is still visible
  assign row_step_s = (vcnt_r[GY_W-1:0] == {GY_W{1'b1}}) &&
                      (vcnt_r < CNT_W'(V_ACTIVE - 1));

  // Running (row * COLS) so the character address needs no multiplier
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_base_r <= {ADDR_W{1'b0}};
    end else if (pix_en_s && h_last_s) begin
      if (v_last_s) begin
        row_base_r <= {ADDR_W{1'b0}};
      end else if (row_step_s) begin
        row_base_r <= row_base_r + ADDR_W'(COLS_L);
      end else begin
        row_base_r <= row_base_r;
      end
    end else begin
      row_base_r <= row_base_r;
    end
  end

  // Undelayed visible-area and sync decode from the counter registers
  always_comb begin
    raw_s        = SYNC_IDLE;
    raw_s.active = (hcnt_r < CNT_W'(H_ACTIVE)) && (vcnt_r < CNT_W'(V_ACTIVE));
    raw_s.hsync  = !((hcnt_r >= CNT_W'(HS_BEG)) && (hcnt_r < CNT_W'(HS_END)));
    raw_s.vsync  = !((vcnt_r >= CNT_W'(VS_BEG)) && (vcnt_r < CNT_W'(VS_END)));
  end

  assign col_s = hcnt_r >> GX_W;

  vga_sync_delay #(
    .DEPTH (PIPE_DLY)
  ) u_sync_delay (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .en    (pix_en_s),
    .din   (raw_s),
    .dout  (dly_s)
  );

  assign pix_en_o      = pix_en_s;
  assign hcnt_o        = hcnt_r;
  assign vcnt_o        = vcnt_r;
  assign char_addr_o   = raw_s.active ? (row_base_r + ADDR_W'(col_s)) : {ADDR_W{1'b0}};
  assign glyph_x_o     = hcnt_r[GX_W-1:0];
  assign glyph_y_o     = vcnt_r[GY_W-1:0];
  assign active_o      = dly_s.active;
  assign hsync_o       = dly_s.hsync;
  assign vsync_o       = dly_s.vsync;
  assign frame_start_o = pix_en_s & h_last_s & v_last_s;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three builds (default, CLK_DIV=1/PIPE_DLY=0 and a
// shrunken raster) compared every cycle against a raster-index reference model.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pix_en;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [12:0] addr;
    logic [2:0]  gx;
    logic [3:0]  gy;
    logic        active;
    logic        hsync;
    logic        vsync;
    logic        fs;
  } obs_t;

  typedef struct {
    int cd; int pd;
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
  } cfg_t;

  typedef struct {
    int which; int h; int v; int addr; int gx; int gy; bit act; bit hit;
  } vec_t;

  localparam int NV = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic pe_a, pe_b, pe_c, ac_a, ac_b, ac_c, hs_a, hs_b, hs_c, vs_a, vs_b, vs_c, fs_a, fs_b, fs_c;
  logic [9:0] hc_a, hc_b, hc_c, vc_a, vc_b, vc_c;
  logic [12:0] ad_a, ad_b, ad_c;
  logic [2:0] gx_a, gx_b, gx_c;
  logic [3:0] gy_a, gy_b, gy_c;
  obs_t o_a, o_b, o_c;

  assign o_a = {pe_a, hc_a, vc_a, ad_a, gx_a, gy_a, ac_a, hs_a, vs_a, fs_a};
  assign o_b = {pe_b, hc_b, vc_b, ad_b, gx_b, gy_b, ac_b, hs_b, vs_b, fs_b};
  assign o_c = {pe_c, hc_c, vc_c, ad_c, gx_c, gy_c, ac_c, hs_c, vs_c, fs_c};

  vga_timing_gen dut_a (
    .clk_i(clk), .rst_ni(rst_a), .pix_en_o(pe_a), .hcnt_o(hc_a), .vcnt_o(vc_a),
    .char_addr_o(ad_a), .glyph_x_o(gx_a), .glyph_y_o(gy_a), .active_o(ac_a),
    .hsync_o(hs_a), .vsync_o(vs_a), .frame_start_o(fs_a));

  vga_timing_gen #(.CLK_DIV(1), .PIPE_DLY(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_b), .pix_en_o(pe_b), .hcnt_o(hc_b), .vcnt_o(vc_b),
    .char_addr_o(ad_b), .glyph_x_o(gx_b), .glyph_y_o(gy_b), .active_o(ac_b),
    .hsync_o(hs_b), .vsync_o(vs_b), .frame_start_o(fs_b));

  vga_timing_gen #(.CLK_DIV(2), .PIPE_DLY(1), .H_ACTIVE(64), .H_FP(8), .H_SYNC(8), .H_BP(8),
                   .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(4)) dut_c (
    .clk_i(clk), .rst_ni(rst_c), .pix_en_o(pe_c), .hcnt_o(hc_c), .vcnt_o(vc_c),
    .char_addr_o(ad_c), .glyph_x_o(gx_c), .glyph_y_o(gy_c), .active_o(ac_c),
    .hsync_o(hs_c), .vsync_o(vs_c), .frame_start_o(fs_c));

  int n_err = 0;
  int n_chk = 0;
  cfg_t cfg_a, cfg_b, cfg_c;
  vec_t vec [NV];

  // Sync bundle {active, hsync_n, vsync_n} at raster position (h, v)
  function automatic logic [2:0] raw_sync(cfg_t g, int h, int v);
    logic a, hs, vs;
    a  = (h < g.ha) && (v < g.va);
    hs = !((h >= g.ha + g.hfp) && (h < g.ha + g.hfp + g.hs));
    vs = !((v >= g.va + g.vfp) && (v < g.va + g.vfp + g.vs));
    return {a, hs, vs};
  endfunction

  // Expected outputs after c clock edges since reset release
  function automatic obs_t model(cfg_t g, int c);
    obs_t m;
    int ht, vt, fr, s, p, h, v, q;
    logic [2:0] d;
    bit act;
    ht = g.ha + g.hfp + g.hs + g.hbp;
    vt = g.va + g.vfp + g.vs + g.vbp;
    fr = ht * vt;
    s  = c / g.cd;
    p  = s % fr;
    h  = p % ht;
    v  = p / ht;
    act      = (h < g.ha) && (v < g.va);
    m.pix_en = ((c % g.cd) == g.cd - 1);
    m.hcnt   = 10'(h);
    m.vcnt   = 10'(v);
    m.addr   = act ? 13'((v / 16) * (g.ha / 8) + h / 8) : 13'd0;
    m.gx     = 3'(h % 8);
    m.gy     = 4'(v % 16);
    if (s >= g.pd) begin
      q = (s - g.pd) % fr;
      d = raw_sync(g, q % ht, q / ht);
    end else begin
      d = 3'b011;
    end
    m.active = d[2];
    m.hsync  = d[1];
    m.vsync  = d[0];
    m.fs     = m.pix_en && (p == fr - 1);
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic apply_vectors();
    obs_t o;
    for (int i = 0; i < NV; i++) begin
      o = (vec[i].which == 1) ? o_b : o_c;
      if (!vec[i].hit && o.hcnt == 10'(vec[i].h) && o.vcnt == 10'(vec[i].v)) begin
        vec[i].hit = 1'b1;
        chk($sformatf("vec%0d_addr", i), o.addr, vec[i].addr);
        chk($sformatf("vec%0d_gx", i), o.gx, vec[i].gx);
        chk($sformatf("vec%0d_gy", i), o.gy, vec[i].gy);
        if (vec[i].which == 1) chk($sformatf("vec%0d_active", i), o.active, vec[i].act);
      end
    end
  endtask

  int c_a, c_b, c_c, hold_a, hold_b, hold_c;
  bit a_epoch0, b_epoch0, go_a, go_b, go_c;
  int first_strobe, a_h656, a_hfall, a_hrise, a_line, b_h656, b_hfall, b_pe_low;
  int c_last_fs, c_vfall, n_fsp, n_vl;
  logic c_prev_vs;

  initial begin
    cfg_a = '{4, 2, 640, 16, 96, 48, 480, 10, 2, 33};
    cfg_b = '{1, 0, 640, 16, 96, 48, 480, 10, 2, 33};
    cfg_c = '{2, 1, 64, 8, 8, 8, 32, 2, 2, 4};
    vec[0] = '{1, 0,   0,  0,   0, 0,  1'b1, 1'b0};
    vec[1] = '{1, 15,  17, 81,  7, 1,  1'b1, 1'b0};
    vec[2] = '{1, 640, 0,  0,   0, 0,  1'b0, 1'b0};
    vec[3] = '{1, 639, 17, 159, 7, 1,  1'b1, 1'b0};
    vec[4] = '{1, 8,   16, 81,  0, 0,  1'b1, 1'b0};
    vec[5] = '{1, 799, 17, 0,   7, 1,  1'b0, 1'b0};
    vec[6] = '{2, 63,  31, 15,  7, 15, 1'b1, 1'b0};
    vec[7] = '{2, 0,   32, 0,   0, 0,  1'b0, 1'b0};
    vec[8] = '{2, 9,   17, 9,   1, 1,  1'b1, 1'b0};
    vec[9] = '{2, 70,  5,  0,   6, 5,  1'b0, 1'b0};

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    c_a = 0; c_b = 0; c_c = 0; hold_a = 0; hold_b = 0; hold_c = 0;
    a_epoch0 = 1'b1; b_epoch0 = 1'b1;
    first_strobe = -1; a_h656 = -1; a_hfall = -1; a_hrise = -1; a_line = -1;
    b_h656 = -1; b_hfall = -1; b_pe_low = 0;
    c_last_fs = -1; c_vfall = -1; n_fsp = 0; n_vl = 0; c_prev_vs = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a", o_a, model(cfg_a, 0));
    chk("reset_b", o_b, model(cfg_b, 0));
    chk("reset_c", o_c, model(cfg_c, 0));
    apply_vectors();
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;

    for (int cyc = 0; cyc < 30000; cyc++) begin
      @(posedge clk);
      if (rst_a) c_a++; else if (hold_a > 0) hold_a--;
      if (rst_b) c_b++; else if (hold_b > 0) hold_b--;
      if (rst_c) c_c++; else if (hold_c > 0) hold_c--;
      @(negedge clk);
      chk("model_a", o_a, model(cfg_a, c_a));
      chk("model_b", o_b, model(cfg_b, c_b));
      chk("model_c", o_c, model(cfg_c, c_c));
      apply_vectors();

      if (a_epoch0) begin
        if (first_strobe < 0 && pe_a) first_strobe = c_a;
        if (a_h656 < 0 && hc_a == 10'd656) a_h656 = c_a;
        if (a_hfall < 0 && !hs_a) a_hfall = c_a;
        if (a_hfall >= 0 && a_hrise < 0 && hs_a) a_hrise = c_a;
        if (a_line < 0 && vc_a == 10'd1 && hc_a == 10'd0) a_line = c_a;
      end
      if (b_epoch0) begin
        if (b_h656 < 0 && hc_b == 10'd656) b_h656 = c_b;
        if (b_hfall < 0 && !hs_b) b_hfall = c_b;
      end
      if (!pe_b) b_pe_low++;
      if (fs_c) begin
        if (c_last_fs >= 0) begin
          chk("frame_period_c", c_c - c_last_fs, 7040);
          n_fsp++;
        end
        c_last_fs = c_c;
      end
      if (c_prev_vs && !vs_c) c_vfall = c_c;
      if (!c_prev_vs && vs_c && c_vfall >= 0) begin
        chk("vsync_low_c", c_c - c_vfall, 352);
        n_vl++;
      end
      c_prev_vs = vs_c;

      if (!rst_a && hold_a == 0) rst_a = 1'b1;
      if (!rst_b && hold_b == 0) rst_b = 1'b1;
      if (!rst_c && hold_c == 0) rst_c = 1'b1;

      go_a = rst_a && ((a_epoch0 && hc_a == 10'd700 && vc_a == 10'd2) ||
                       (cyc > 16000 && $urandom_range(0, 1499) == 0));
      go_b = rst_b && cyc > 16000 && $urandom_range(0, 1499) == 0;
      go_c = rst_c && cyc > 16000 && $urandom_range(0, 999) == 0;
      if (go_a || go_b || go_c) begin
        #2;
        if (go_a) begin
          rst_a = 1'b0; c_a = 0;
          hold_a = a_epoch0 ? 3 : int'($urandom_range(1, 4));
          a_epoch0 = 1'b0;
        end
        if (go_b) begin
          rst_b = 1'b0; c_b = 0; hold_b = int'($urandom_range(1, 4)); b_epoch0 = 1'b0;
        end
        if (go_c) begin
          rst_c = 1'b0; c_c = 0; hold_c = int'($urandom_range(1, 4));
          c_last_fs = -1; c_vfall = -1; c_prev_vs = 1'b1;
        end
        #1;
        if (go_a) chk("async_rst_a", o_a, model(cfg_a, 0));
        if (go_b) chk("async_rst_b", o_b, model(cfg_b, 0));
        if (go_c) chk("async_rst_c", o_c, model(cfg_c, 0));
      end
    end

    chk("first_strobe_c3", first_strobe, 3);
    chk("h656_to_hsync_fall", a_hfall - a_h656, 8);
    chk("hsync_low_clocks", a_hrise - a_hfall, 384);
    chk("line_period", a_line, 3200);
    chk("b_hsync_same_clock", b_hfall - b_h656, 0);
    chk("b_pix_en_low_count", b_pe_low, 0);
    chk("frame_period_seen", (n_fsp > 0), 1);
    chk("vsync_low_seen", (n_vl > 0), 1);
    for (int i = 0; i < NV; i++) chk($sformatf("vec%0d_visited", i), vec[i].hit, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Pixel-timing and character-addressing stage inside vgachargen_wrapper, downstream of the APB-facing char/addr/wen capture.
- Generates 640x480@60 VGA timing from the system clock using a pixel strobe.
- Produces the character-cell address and glyph row/column consumed by the character RAM and glyph ROM.
- hSYNC/vSYNC/active are delayed to align with the downstream RAM+ROM read latency.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz pixel rate); must be >= 1.
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in pixels; H_TOTAL = 800.
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines; V_TOTAL = 525.
- CHAR_W, 8, glyph width in pixels (power of 2).
- CHAR_H, 16, glyph height in lines (power of 2).
- COLS, 80, H_ACTIVE/CHAR_W.
- ADDR_W, 13, character-address width; COLS*(V_ACTIVE/CHAR_H) must be <= 2^ADDR_W.
- PIPE_DLY, 2, pixel strobes of delay applied to sync/active outputs; 0 allowed.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- pix_en_o  out  1  pixel strobe, one clk_i high every CLK_DIV clocks
- hcnt_o  out  10  horizontal pixel counter 0..H_TOTAL-1
- vcnt_o  out  10  vertical line counter 0..V_TOTAL-1
- char_addr_o  out  ADDR_W  (vcnt/CHAR_H)*COLS + hcnt/CHAR_W; 0 when not active
- glyph_x_o  out  log2(CHAR_W)  hcnt mod CHAR_W
- glyph_y_o  out  log2(CHAR_H)  vcnt mod CHAR_H
- active_o  out  1  visible-area flag, delayed PIPE_DLY strobes
- hsync_o  out  1  active-low hsync, delayed PIPE_DLY strobes
- vsync_o  out  1  active-low vsync, delayed PIPE_DLY strobes
- frame_start_o  out  1  one-clk pulse on the strobe where the counters wrap to (0,0)

Behaviour:
- Reset:
  - divider, hcnt, vcnt, char_addr, glyph_x/y = 0
  - pix_en_o = 0, active_o = 0, frame_start_o = 0
  - hsync_o = vsync_o = 1 (inactive); every delay stage is reset to inactive values.
- Divider:
  - Counts 0..CLK_DIV-1 and wraps.
  - pix_en_o is combinational: 1 when divider == CLK_DIV-1.
  - First strobe occurs CLK_DIV clocks after reset release.
  - CLK_DIV == 1 gives pix_en_o constantly 1.
- Counters advance only on clocks where pix_en_o = 1:
  - hcnt increments; at H_TOTAL-1 it wraps to 0 and vcnt increments.
  - vcnt wraps from V_TOTAL-1 to 0 on the same strobe in which hcnt wraps.
- Raw (undelayed) signals, combinational from the counter registers:
  - active = (hcnt < H_ACTIVE) & (vcnt < V_ACTIVE)
  - hsync = 0 for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) = [656,752)
  - vsync = 0 for vcnt in [490,492)
- Addressing:
  - char_addr_o, glyph_x_o and glyph_y_o are zero-latency, combinational from hcnt/vcnt.
  - char_addr_o is forced to 0 outside the visible area.
  - Implement without a multiplier: keep a row-base register that adds COLS on each CHAR_H-line boundary and clears at vcnt wrap.
  - Max value is 29*80+79 = 2399.
- Delay line:
  - A PIPE_DLY-deep shift register carries {active, hsync, vsync}, shifting only on pix_en.
  - Outputs change only on strobe clocks, PIPE_DLY strobes after the raw value.
  - With PIPE_DLY = 0 the outputs equal the raw values.
- frame_start_o = pix_en & (hcnt == H_TOTAL-1) & (vcnt == V_TOTAL-1).
- Reset asserted mid-frame: everything returns to reset values immediately (async). After release, timing restarts at (0,0) with no partial sync pulse.

Decomposition:
- vga_pkg holds:
  - timing constants (H_*/V_*, H_TOTAL, V_TOTAL)
  - CHAR_W, CHAR_H, COLS, ROWS
  - derived widths (GLYPH_X_W, GLYPH_Y_W)
  - typedef sync_t = struct {active, hsync, vsync}
- One sub-module: vga_sync_delay, a parameterized PIPE_DLY-deep, pix_en-gated shift register of sync_t with inactive reset values.

Test Plan:
- Reset, then release; count clocks -> pix_en_o first high at clock 4 and every 4 clocks after; hsync_o/vsync_o = 1 and active_o = 0 before the first strobe.
- Run one line, PIPE_DLY=2 -> hsync_o falls 2 strobes after hcnt_o = 656, stays low for 96 strobes (384 clocks); line period 3200 clocks.
- Run a full frame -> frame_start_o pulses are 1,680,000 clocks apart; vsync_o is low for exactly 2 lines (6400 clocks).
- Sample at (hcnt, vcnt):
  - (0,0) -> char_addr 0, glyph 0/0
  - (15,17) -> addr 81, glyph_x 7, glyph_y 1
  - (639,479) -> 2399, 7/15
  - (640,0) -> 0 with raw active 0
- Assert rst_ni at hcnt = 700 of line 200, release after 3 clocks -> outputs at reset values during reset; counters restart at 0/0; no short hsync glitch.
- PIPE_DLY=0, CLK_DIV=1 build -> hsync_o falls on the same clock hcnt_o becomes 656; pix_en_o stuck at 1.
